// File: rtl/muldiv_unit.sv
// Multi-cycle multiply/divide unit owning the HI/LO pair (MULT/MULTU/DIV/DIVU, MTHI/MTLO).
// Magnitudes are iterated one bit per cycle, then sign-fixed and written in a final FIX cycle.
module muldiv_unit #(
   parameter int WIDTH = 32,
   parameter int CNT_W = 5
) (
   input  logic             CLK,
   input  logic             RST_N,
   input  logic             start,
   input  logic [1:0]       op,
   input  logic [WIDTH-1:0] A,
   input  logic [WIDTH-1:0] B,
   input  logic             mthi,
   input  logic             mtlo,
   output logic [WIDTH-1:0] HI,
   output logic [WIDTH-1:0] LO,
   output logic             busy,
   output logic             done
);

   typedef enum logic [1:0] {IDLE, RUN, FIX} state_t;

   localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH-1);

   state_t             state, state_nxt;
   logic [WIDTH-1:0]   hi_q, lo_q;
   logic [WIDTH-1:0]   opnd;   // multiplicand or divisor magnitude
   logic [WIDTH-1:0]   acc;    // product high half / partial remainder
   logic [WIDTH-1:0]   sh;     // multiplier shifting out / dividend shifting into quotient
   logic [CNT_W-1:0]   cnt;
   logic               is_div, neg_p, neg_r, div_zero;
   logic               busy_q, done_q;

   logic               a_neg, b_neg;
   logic [WIDTH-1:0]   a_mag, b_mag;
   logic [WIDTH:0]     add_sum, sub_diff;
   logic [2*WIDTH-1:0] prod, prod_fix;
   logic [WIDTH-1:0]   quo_fix, rem_fix;

   assign a_neg = ~op[0] & A[WIDTH-1];
   assign b_neg = ~op[0] & B[WIDTH-1];
   assign a_mag = a_neg ? -A : A;
   assign b_mag = b_neg ? -B : B;

   always_comb begin
      add_sum  = {1'b0, acc} + (sh[0] ? {1'b0, opnd} : '0);
      // MSB of the difference is the borrow: set when the trial subtract fails
      sub_diff = {acc, sh[WIDTH-1]} - {1'b0, opnd};
      prod     = {acc, sh};
      prod_fix = neg_p ? -prod : prod;
      quo_fix  = neg_p ? -sh : sh;
      rem_fix  = neg_r ? -acc : acc;
   end

   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) state <= IDLE;
      else        state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (start) state_nxt = RUN;
         RUN:     if (cnt == LAST) state_nxt = FIX;
         FIX:     state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         hi_q     <= '0;
         lo_q     <= '0;
         opnd     <= '0;
         acc      <= '0;
         sh       <= '0;
         cnt      <= '0;
         is_div   <= 1'b0;
         neg_p    <= 1'b0;
         neg_r    <= 1'b0;
         div_zero <= 1'b0;
         busy_q   <= 1'b0;
         done_q   <= 1'b0;
      end else begin
         busy_q <= (state_nxt != IDLE);
         done_q <= (state == FIX);
         case (state)
            IDLE: begin
               if (start) begin
                  opnd     <= op[1] ? b_mag : a_mag;
                  sh       <= op[1] ? a_mag : b_mag;
                  acc      <= '0;
                  cnt      <= '0;
                  is_div   <= op[1];
                  neg_p    <= a_neg ^ b_neg;
                  neg_r    <= a_neg;
                  div_zero <= op[1] & (B == '0);
               end else begin
                  if (mthi) hi_q <= A;
                  if (mtlo) lo_q <= A;
               end
            end
            RUN: begin
               cnt <= cnt + CNT_W'(1);
               if (is_div) begin
                  if (!sub_diff[WIDTH]) begin
                     acc <= sub_diff[WIDTH-1:0];
                     sh  <= {sh[WIDTH-2:0], 1'b1};
                  end else begin
                     acc <= {acc[WIDTH-2:0], sh[WIDTH-1]};
                     sh  <= {sh[WIDTH-2:0], 1'b0};
                  end
               end else begin
                  acc <= add_sum[WIDTH:1];
                  sh  <= {add_sum[0], sh[WIDTH-1:1]};
               end
            end
            FIX: begin
               if (!is_div) begin
                  hi_q <= prod_fix[2*WIDTH-1:WIDTH];
                  lo_q <= prod_fix[WIDTH-1:0];
               end else if (!div_zero) begin
                  hi_q <= rem_fix;
                  lo_q <= quo_fix;
               end
            end
            default: ;
         endcase
      end
   end

   assign HI   = hi_q;
   assign LO   = lo_q;
   assign busy = busy_q;
   assign done = done_q;

endmodule

// File: tb/tb_muldiv_unit.sv
// Directed bench for muldiv_unit: arithmetic results, latency, conflicts and async reset.
module tb_muldiv_unit;

   logic        CLK = 1'b0;
   logic        RST_N;
   logic        start, mthi, mtlo;
   logic [1:0]  op;
   logic [31:0] A, B, HI, LO;
   logic        busy, done;
   int          checks = 0;
   int          errors = 0;

   always #5 CLK = ~CLK;

   muldiv_unit #(.WIDTH(32), .CNT_W(5)) dut (
      .CLK(CLK), .RST_N(RST_N), .start(start), .op(op), .A(A), .B(B),
      .mthi(mthi), .mtlo(mtlo), .HI(HI), .LO(LO), .busy(busy), .done(done)
   );

   // Issues one op, scrambles A/B after the start edge, returns edges-to-done and busy cycles.
   task automatic run_op(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                         output int lat, output int bc);
      @(negedge CLK); start = 1'b1; op = o; A = a; B = b;
      @(posedge CLK); #1; start = 1'b0; A = 32'hA5A5_5A5A; B = 32'h0F0F_F0F0;
      lat = -1;
      bc  = busy ? 1 : 0;
      for (int k = 1; k <= 40; k++) begin
         @(posedge CLK); #1;
         if (done) begin lat = k; break; end
         if (busy) bc++;
      end
   endtask

   task automatic test_reset;
      RST_N = 1'b0; start = 1'b0; mthi = 1'b0; mtlo = 1'b0; op = 2'b00; A = '0; B = '0;
      #12;
      checks++; if (HI !== 32'h0) begin errors++; $display("FAIL reset_hi: got %h want 0", HI); end
      checks++; if (LO !== 32'h0) begin errors++; $display("FAIL reset_lo: got %h want 0", LO); end
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b want 0", busy); end
      checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done: got %b want 0", done); end
      @(negedge CLK); RST_N = 1'b1;
   endtask

   task automatic test_multu;
      int lat, bc;
      run_op(2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, lat, bc);
      checks++; if (lat !== 33) begin errors++; $display("FAIL multu_latency: got %0d want 33", lat); end
      checks++; if (bc !== 33) begin errors++; $display("FAIL multu_busy_cycles: got %0d want 33", bc); end
      checks++; if (HI !== 32'hFFFF_FFFE) begin errors++; $display("FAIL multu_hi: got %h want fffffffe", HI); end
      checks++; if (LO !== 32'h0000_0001) begin errors++; $display("FAIL multu_lo: got %h want 00000001", LO); end
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL multu_busy_at_done: got %b want 0", busy); end
      @(posedge CLK); #1;
      checks++; if (done !== 1'b0) begin errors++; $display("FAIL multu_done_pulse: got %b want 0", done); end
   endtask

   task automatic test_signed;
      int lat, bc;
      run_op(2'b00, 32'hFFFF_FFF9, 32'd3, lat, bc);
      checks++; if (HI !== 32'hFFFF_FFFF) begin errors++; $display("FAIL mult_hi: got %h want ffffffff", HI); end
      checks++; if (LO !== 32'hFFFF_FFEB) begin errors++; $display("FAIL mult_lo: got %h want ffffffeb", LO); end
      run_op(2'b10, 32'hFFFF_FFF9, 32'd2, lat, bc);
      checks++; if (lat !== 33) begin errors++; $display("FAIL div_latency: got %0d want 33", lat); end
      checks++; if (LO !== 32'hFFFF_FFFD) begin errors++; $display("FAIL div_lo: got %h want fffffffd", LO); end
      checks++; if (HI !== 32'hFFFF_FFFF) begin errors++; $display("FAIL div_hi: got %h want ffffffff", HI); end
   endtask

   task automatic test_mt;
      @(negedge CLK); mthi = 1'b1; mtlo = 1'b1; A = 32'h0000_ABCD;
      @(posedge CLK); #1; mthi = 1'b0; mtlo = 1'b0;
      checks++; if (HI !== 32'h0000_ABCD) begin errors++; $display("FAIL mt_both_hi: got %h want 0000abcd", HI); end
      checks++; if (LO !== 32'h0000_ABCD) begin errors++; $display("FAIL mt_both_lo: got %h want 0000abcd", LO); end
      @(negedge CLK); mthi = 1'b1; A = 32'h0000_1234;
      @(posedge CLK); #1; mthi = 1'b0;
      @(negedge CLK); mtlo = 1'b1; A = 32'h0000_5678;
      @(posedge CLK); #1; mtlo = 1'b0;
      checks++; if (HI !== 32'h0000_1234) begin errors++; $display("FAIL mthi: got %h want 00001234", HI); end
      checks++; if (LO !== 32'h0000_5678) begin errors++; $display("FAIL mtlo: got %h want 00005678", LO); end
   endtask

   task automatic test_overflow_divzero;
      int lat, bc;
      run_op(2'b10, 32'h8000_0000, 32'hFFFF_FFFF, lat, bc);
      checks++; if (LO !== 32'h8000_0000) begin errors++; $display("FAIL div_ovf_lo: got %h want 80000000", LO); end
      checks++; if (HI !== 32'h0) begin errors++; $display("FAIL div_ovf_hi: got %h want 0", HI); end
      test_mt();
      run_op(2'b11, 32'd99, 32'd0, lat, bc);
      checks++; if (lat !== 33) begin errors++; $display("FAIL divz_done: got latency %0d want 33", lat); end
      checks++; if (HI !== 32'h0000_1234) begin errors++; $display("FAIL divz_hi: got %h want 00001234", HI); end
      checks++; if (LO !== 32'h0000_5678) begin errors++; $display("FAIL divz_lo: got %h want 00005678", LO); end
   endtask

   task automatic test_conflicts;
      int lat;
      @(negedge CLK); start = 1'b1; op = 2'b01; A = 32'd5; B = 32'd6;
      @(posedge CLK); #1; start = 1'b0;
      for (int k = 1; k <= 9; k++) @(posedge CLK);
      @(negedge CLK); start = 1'b1; op = 2'b11; A = 32'd100; B = 32'd7;
      @(posedge CLK); #1; start = 1'b0; mthi = 1'b1; A = 32'h0000_DEAD;
      @(posedge CLK); #1; mthi = 1'b0;
      checks++; if (HI !== 32'h0000_1234) begin errors++; $display("FAIL busy_mthi_ignored: got %h want 00001234", HI); end
      lat = -1;
      for (int k = 12; k <= 45; k++) begin
         @(posedge CLK); #1;
         if (done) begin lat = k; break; end
      end
      checks++; if (lat !== 33) begin errors++; $display("FAIL conflict_latency: got %0d want 33", lat); end
      checks++; if (HI !== 32'h0) begin errors++; $display("FAIL conflict_hi: got %h want 0", HI); end
      checks++; if (LO !== 32'd30) begin errors++; $display("FAIL conflict_lo: got %h want 0000001e", LO); end
   endtask

   task automatic test_back_to_back;
      int lat, bc;
      // run_op launches its start in the done cycle left by the previous op
      run_op(2'b11, 32'd100, 32'd7, lat, bc);
      checks++; if (lat !== 33) begin errors++; $display("FAIL b2b_latency: got %0d want 33", lat); end
      checks++; if (LO !== 32'd14) begin errors++; $display("FAIL b2b_lo: got %h want 0000000e", LO); end
      checks++; if (HI !== 32'd2) begin errors++; $display("FAIL b2b_hi: got %h want 00000002", HI); end
   endtask

   task automatic test_start_wins;
      int lat;
      @(negedge CLK); start = 1'b1; op = 2'b01; A = 32'd3; B = 32'd4; mthi = 1'b1; mtlo = 1'b1;
      @(posedge CLK); #1; start = 1'b0; mthi = 1'b0; mtlo = 1'b0;
      checks++; if (HI !== 32'd2) begin errors++; $display("FAIL start_wins_hi: got %h want 00000002", HI); end
      checks++; if (LO !== 32'd14) begin errors++; $display("FAIL start_wins_lo: got %h want 0000000e", LO); end
      checks++; if (busy !== 1'b1) begin errors++; $display("FAIL start_wins_busy: got %b want 1", busy); end
      lat = -1;
      for (int k = 1; k <= 40; k++) begin
         @(posedge CLK); #1;
         if (done) begin lat = k; break; end
      end
      checks++; if (lat !== 33) begin errors++; $display("FAIL start_wins_latency: got %0d want 33", lat); end
      checks++; if (LO !== 32'd12) begin errors++; $display("FAIL start_wins_result: got %h want 0000000c", LO); end
   endtask

   task automatic test_reset_mid_op;
      int lat, bc;
      @(negedge CLK); start = 1'b1; op = 2'b01; A = 32'h0001_0000; B = 32'h0001_0000;
      @(posedge CLK); #1; start = 1'b0;
      for (int k = 1; k <= 15; k++) @(posedge CLK);
      #2; RST_N = 1'b0;
      #1;
      checks++; if (HI !== 32'h0) begin errors++; $display("FAIL midrst_hi: got %h want 0", HI); end
      checks++; if (LO !== 32'h0) begin errors++; $display("FAIL midrst_lo: got %h want 0", LO); end
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL midrst_busy: got %b want 0", busy); end
      repeat (3) @(posedge CLK);
      @(negedge CLK); RST_N = 1'b1;
      repeat (25) @(posedge CLK);
      #1;
      checks++; if (done !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL midrst_no_resume: got done=%b busy=%b want 0 0", done, busy); end
      checks++; if (HI !== 32'h0) begin errors++; $display("FAIL midrst_no_partial: got HI %h want 0", HI); end
      run_op(2'b01, 32'd2, 32'd3, lat, bc);
      checks++; if (lat !== 33) begin errors++; $display("FAIL post_rst_latency: got %0d want 33", lat); end
      checks++; if (LO !== 32'd6) begin errors++; $display("FAIL post_rst_lo: got %h want 00000006", LO); end
      checks++; if (HI !== 32'h0) begin errors++; $display("FAIL post_rst_hi: got %h want 0", HI); end
   endtask

   initial begin
      test_reset();
      test_multu();
      test_signed();
      test_mt();
      test_overflow_divzero();
      test_conflicts();
      test_back_to_back();
      test_start_wins();
      test_reset_mid_op();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/muldiv_unit.md
# muldiv_unit

Multi-cycle multiply/divide unit that owns the HI/LO register pair for MULT, MULTU, DIV, DIVU, MTHI and MTLO. It sits beside the single-cycle ALU in the execute stage: decode issues operations to it, and the ALU's MFHI/MFLO path reads its HI/LO outputs. The `busy` output stalls issue of a dependent MFHI/MFLO or of a new multiply/divide.

## Interface

**Parameters**
- `WIDTH`, default 32: operand and HI/LO width.
- `CNT_W`, default 5: iteration counter width; log2(WIDTH).

**Ports**
- `CLK` input, 1: single clock. All state changes on the rising edge.
- `RST_N` input, 1: reset. Asynchronous, active-low.
- `start` input, 1: issue a mult/div operation. Sampled only in IDLE.
- `op` input, 2: operation select. 00 MULT, 01 MULTU, 10 DIV, 11 DIVU.
- `A` input, WIDTH: rs operand (multiplicand/dividend); also the MTHI/MTLO source.
- `B` input, WIDTH: rt operand (multiplier/divisor).
- `mthi` input, 1: write A to HI. Honoured only in IDLE with `start`=0.
- `mtlo` input, 1: write A to LO. Same rule as `mthi`.
- `HI` output, WIDTH: upper product / remainder register.
- `LO` output, WIDTH: lower product / quotient register.
- `busy` output, 1: an operation is in progress.
- `done` output, 1: one-cycle pulse when HI/LO have just been updated by an operation.

## Operation

**Reset**
- HI=0, LO=0, `busy`=0, `done`=0, state=IDLE, counter=0.
- Reset aborts any operation in flight; no partial result reaches HI/LO.

**States**
- IDLE
  - `start`=1: latch |A| and |B| (signed ops) or A and B (unsigned ops), the result signs and `op`; clear the accumulator and counter; go to RUN.
  - Else if `mthi`/`mtlo`: write A into HI/LO. Both may be set together.
- RUN: one shift-add (multiply) or restoring-subtract (divide) step per cycle, MSB/LSB-first as appropriate. Exits to FIX after the step with counter = WIDTH-1.
- FIX: apply sign fixup, write HI/LO, set `done`, go to IDLE.

**Arithmetic**
- MULT: 64-bit two's-complement product of signed A and B. HI = bits 63:32, LO = bits 31:0.
- MULTU: unsigned 64-bit product.
- DIV: LO = quotient truncated toward zero; HI = remainder with the sign of the dividend.
  - 0x80000000 / 0xFFFFFFFF gives LO=0x80000000, HI=0 (wraps, no trap).
- DIVU: unsigned quotient/remainder.
- Divide by zero (DIV or DIVU with B=0): runs the full latency, but HI and LO are left unchanged. `done` still pulses.
- Product and quotient magnitudes are computed in a WIDTH-bit unsigned datapath. Negation is two's complement over 2*WIDTH bits (product) or WIDTH bits (quotient/remainder).

**Conflicts**
- `start` while `busy`=1: ignored. The operation is not queued.
- `mthi`/`mtlo` while `busy`=1: ignored.
- `start` together with `mthi`/`mtlo` in IDLE: start wins, the MT write is dropped.
- A and B may change after the start edge without affecting the result.

## Timing

- Start accepted at rising edge E0 (IDLE, `start`=1).
- `busy`=1 from after E0 through the cycle before E33 (RUN is E1..E32; FIX is the cycle ending at E33).
- At E33: HI/LO are written, `done`=1 for exactly one cycle, and `busy`=0.
- Latency from start edge to result visible is 33 cycles.
- A new `start` is accepted in the same cycle that `done`=1.
- MTHI/MTLO take effect at the next edge; HI/LO are visible the following cycle.
- HI, LO, `busy` and `done` are all driven straight from registers; no combinational path from inputs to outputs.
- Reset asserted asynchronously in any state forces the reset values immediately.

## Test plan

1. **MULTU**: A=0xFFFFFFFF, B=0xFFFFFFFF -> at E33 HI=0xFFFFFFFE, LO=0x00000001, `done` pulses once, `busy` was high for 33 cycles.
2. **MULT**: A=0xFFFFFFF9 (-7), B=3 -> HI=0xFFFFFFFF, LO=0xFFFFFFEB. Then DIV with A=0xFFFFFFF9, B=2 -> LO=0xFFFFFFFD, HI=0xFFFFFFFF.
3. **Overflow and divide by zero**: DIV A=0x80000000, B=0xFFFFFFFF -> LO=0x80000000, HI=0. Then DIVU with B=0, after MTHI 0x1234 and MTLO 0x5678 -> HI=0x1234, LO=0x5678 unchanged, `done` still pulses at E33.
4. **Conflicts**: `start` with A=5, B=6 (MULTU); at E10 pulse `start` (DIVU 100/7) and `mthi` A=0xDEAD -> both ignored, result HI=0, LO=30. Back-to-back `start` in the `done` cycle is accepted.
5. **Reset mid-operation**: drop `RST_N` at E15 of MULTU 0x10000*0x10000 -> HI=LO=0, `busy`=0 immediately. After release, a fresh MULTU 2*3 gives LO=6, HI=0.
